gpmc_fifo_bridge: RTL and testbench

- Sits directly downstream of the GPMC synchronizer and consumes its decoded bus: cs, we, oe, address, received write data; it returns read data.
- Turns GPMC accesses into two stream FIFOs: host->fabric (TX) and fabric->host (RX).
- Adds a status register and a control register, so the ARM host can exchange data with fabric logic through four memory-mapped registers.

---
 rtl/gpmc_fifo_bridge.sv | 272 +++++++++++++++++++++++++++
 tb/tb_gpmc_fifo_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpmc_fifo_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gpmc_fifo_bridge                                              |
// | Purpose  : GPMC register window onto a host->fabric (TX) and a           |
// |            fabric->host (RX) stream FIFO, plus STATUS and CTRL regs.     |
// | Option   : GPMC_FIFO_LEVEL_EN adds the LEVEL register at address 4.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module gpmc_fifo_bridge_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty
`ifdef GPMC_FIFO_LEVEL_EN
   ,
   output logic [DEPTH_LOG2:0]   level
`endif
);

   localparam int c_depth = 2 ** DEPTH_LOG2;

   logic [DEPTH_LOG2:0]   r_wptr;
   logic [DEPTH_LOG2:0]   r_rptr;
   logic [DATA_WIDTH-1:0] r_mem [c_depth];
   logic                  w_do_push;
   logic                  w_do_pop;

   assign empty = (r_wptr == r_rptr);
   assign full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                  (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
   assign head  = r_mem[r_rptr[DEPTH_LOG2-1:0]];

   // A push into a full FIFO is still taken when a legal pop frees a slot in the same cycle.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

`ifdef GPMC_FIFO_LEVEL_EN
   assign level = r_wptr - r_rptr;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= wdata;
   end

endmodule

module gpmc_fifo_bridge #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic                  we,
   input  logic                  oe,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] bus_wdata,
   output logic [DATA_WIDTH-1:0] bus_rdata,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready
);

   localparam logic [ADDR_WIDTH-1:0] c_addr_status = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] c_addr_tx     = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] c_addr_rx     = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] c_addr_ctrl   = ADDR_WIDTH'(3);
`ifdef GPMC_FIFO_LEVEL_EN
   localparam logic [ADDR_WIDTH-1:0] c_addr_level  = ADDR_WIDTH'(4);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_wr_cond;
   logic                  w_rd_cond;
   logic                  w_wr_end;
   logic                  w_rd_end;

   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [ADDR_WIDTH-1:0] r_raddr;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_tx_ovf;
   logic                  r_rx_udf;

   logic                  w_tx_push;
   logic                  w_tx_full;
   logic                  w_tx_empty;
   logic                  w_tx_flush;
   logic                  w_rx_pop;
   logic                  w_rx_full;
   logic                  w_rx_empty;
   logic                  w_rx_flush;
   logic [DATA_WIDTH-1:0] w_rx_head;
   logic                  w_ctrl_wr;
   logic                  w_tx_ovf_set;
   logic                  w_rx_udf_set;
   logic [DATA_WIDTH-1:0] w_status;
   logic [DATA_WIDTH-1:0] w_rd_mux;
`ifdef GPMC_FIFO_LEVEL_EN
   logic [DEPTH_LOG2:0]   w_tx_level;
   logic [DEPTH_LOG2:0]   w_rx_level;
`endif

   assign w_wr_cond = !cs && !we &&  oe;
   assign w_rd_cond = !cs &&  we && !oe;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = IDLE;
      w_wr_end     = 1'b0;
      w_rd_end     = 1'b0;
      case (r_state)
         IDLE, WR: begin
            if (w_wr_cond)      w_next_state = WR;
            else if (w_rd_cond) w_next_state = RD;
         end
         RD: begin
            if (w_rd_cond) w_next_state = RD;
         end
         default: w_next_state = IDLE;
      endcase
      w_wr_end = (r_state == WR) && (w_next_state != WR);
      w_rd_end = (r_state == RD) && (w_next_state != RD);
   end

   // Side effects act on the values captured during the access, one cycle behind the bus.
   assign w_tx_push    = w_wr_end && (r_waddr == c_addr_tx);
   assign w_ctrl_wr    = w_wr_end && (r_waddr == c_addr_ctrl);
   assign w_tx_flush   = w_ctrl_wr && r_wdata[0];
   assign w_rx_flush   = w_ctrl_wr && r_wdata[1];
   assign w_rx_pop     = w_rd_end && (r_raddr == c_addr_rx);
   assign w_tx_ovf_set = w_tx_push && w_tx_full && !(tx_valid && tx_ready);
   assign w_rx_udf_set = w_rx_pop && w_rx_empty;

   gpmc_fifo_bridge_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_tx_push),
      .pop   (tx_ready),
      .flush (w_tx_flush),
      .wdata (r_wdata),
      .head  (tx_data),
      .full  (w_tx_full),
      .empty (w_tx_empty)
`ifdef GPMC_FIFO_LEVEL_EN
      ,
      .level (w_tx_level)
`endif
   );

   gpmc_fifo_bridge_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_valid),
      .pop   (w_rx_pop),
      .flush (w_rx_flush),
      .wdata (rx_data),
      .head  (w_rx_head),
      .full  (w_rx_full),
      .empty (w_rx_empty)
`ifdef GPMC_FIFO_LEVEL_EN
      ,
      .level (w_rx_level)
`endif
   );

   assign tx_valid  = !w_tx_empty;
   assign rx_ready  = !w_rx_full;
   assign bus_rdata = r_rdata;

   always_comb begin
      w_status    = '0;
      w_status[0] = w_tx_full;
      w_status[1] = w_tx_empty;
      w_status[2] = w_rx_full;
      w_status[3] = w_rx_empty;
      w_status[4] = r_tx_ovf;
      w_status[5] = r_rx_udf;
   end

   always_comb begin
      w_rd_mux = '0;
      if (address == c_addr_status) begin
         w_rd_mux = w_status;
      end else if (address == c_addr_rx) begin
         w_rd_mux = w_rx_empty ? '0 : w_rx_head;
      end
`ifdef GPMC_FIFO_LEVEL_EN
      else if (address == c_addr_level) begin
         w_rd_mux[DEPTH_LOG2:0]        = w_tx_level;
         w_rd_mux[8 +: DEPTH_LOG2 + 1] = w_rx_level;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_waddr <= '0;
         r_wdata <= '0;
         r_raddr <= '0;
         r_rdata <= '0;
      end else begin
         if (w_next_state == WR) begin
            r_waddr <= address;
            r_wdata <= bus_wdata;
         end
         if (w_rd_cond) begin
            r_raddr <= address;
            r_rdata <= w_rd_mux;
         end
      end
   end

   // A new overflow/underflow outranks a clear request in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_ovf <= 1'b0;
         r_rx_udf <= 1'b0;
      end else begin
         if (w_tx_ovf_set)                r_tx_ovf <= 1'b1;
         else if (w_ctrl_wr && r_wdata[2]) r_tx_ovf <= 1'b0;
         if (w_rx_udf_set)                r_rx_udf <= 1'b1;
         else if (w_ctrl_wr && r_wdata[2]) r_rx_udf <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gpmc_fifo_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_gpmc_fifo_bridge                                           |
// | Purpose  : Directed bench for gpmc_fifo_bridge (honours GPMC_FIFO_LEVEL_EN)|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_gpmc_fifo_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs, we, oe;
   logic [9:0]  address;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] pop_q [$];

   gpmc_fifo_bridge #(
      .ADDR_WIDTH (10),
      .DATA_WIDTH (16),
      .DEPTH_LOG2 (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cs        (cs),
      .we        (we),
      .oe        (oe),
      .address   (address),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready)
   );

   always #5 clk = ~clk;

   // Record every TX word the fabric takes; inputs are stable by the falling edge.
   always @(negedge clk) begin
      if (tx_valid === 1'b1 && tx_ready === 1'b1) pop_q.push_back(tx_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      cs = 1'b1; we = 1'b1; oe = 1'b1;
   endtask

   task automatic bus_write(input logic [9:0] a, input logic [15:0] d, input int n);
      cs = 1'b0; we = 1'b0; oe = 1'b1; address = a; bus_wdata = d;
      repeat (n) tick();
      bus_idle();
      tick();
   endtask

   task automatic bus_read(input logic [9:0] a, input int n, output logic [15:0] d);
      cs = 1'b0; we = 1'b1; oe = 1'b0; address = a;
      repeat (n) tick();
      d = bus_rdata;
      bus_idle();
      tick();
   endtask

   task automatic rx_push(input logic [15:0] d);
      rx_valid = 1'b1; rx_data = d;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      reset = 1'b1; bus_idle(); address = '0; bus_wdata = '0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      total++; if (bus_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", bus_rdata); end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h000A) begin bad++; $display("FAIL reset_status got=%h exp=000a", d); end
   endtask

   task automatic test_tx_stream();
      tx_ready = 1'b1;
      pop_q.delete();
      bus_write(10'd1, 16'h1234, 3);
      bus_write(10'd1, 16'hBEEF, 3);
      repeat (3) tick();
      total++; if (pop_q.size() !== 2) begin bad++; $display("FAIL tx_pop_count got=%0d exp=2", pop_q.size()); end
      if (pop_q.size() >= 2) begin
         total++; if (pop_q[0] !== 16'h1234) begin bad++; $display("FAIL tx_word0 got=%h exp=1234", pop_q[0]); end
         total++; if (pop_q[1] !== 16'hBEEF) begin bad++; $display("FAIL tx_word1 got=%h exp=beef", pop_q[1]); end
      end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_empty_after got=%b exp=0", tx_valid); end
      tx_ready = 1'b0;
   endtask

   task automatic test_tx_overflow();
      logic [15:0] d;
      for (int i = 0; i < 16; i++) bus_write(10'd1, 16'hA5A5, 1);
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h0009) begin bad++; $display("FAIL tx_full_status got=%h exp=0009", d); end
      total++; if (tx_data !== 16'hA5A5 || tx_valid !== 1'b1) begin bad++; $display("FAIL tx_head got=%h/%b exp=a5a5/1", tx_data, tx_valid); end
      bus_write(10'd1, 16'hA5A5, 1);
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h0019) begin bad++; $display("FAIL tx_ovf_status got=%h exp=0019", d); end
      bus_write(10'd3, 16'h0005, 1);
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h000A) begin bad++; $display("FAIL ctrl_flush_status got=%h exp=000a", d); end
   endtask

   task automatic test_rx_underflow();
      logic [15:0] d;
      bus_read(10'd2, 1, d);
      total++; if (d !== 16'h0000) begin bad++; $display("FAIL rx_empty_read got=%h exp=0000", d); end
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h002A) begin bad++; $display("FAIL rx_udf_status got=%h exp=002a", d); end
      rx_push(16'h00C3);
      rx_push(16'h0077);
      bus_read(10'd2, 4, d);
      total++; if (d !== 16'h00C3) begin bad++; $display("FAIL rx_read_c3 got=%h exp=00c3", d); end
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h0022) begin bad++; $display("FAIL rx_one_pop_status got=%h exp=0022", d); end
      bus_read(10'd2, 1, d);
      total++; if (d !== 16'h0077) begin bad++; $display("FAIL rx_read_77 got=%h exp=0077", d); end
      bus_write(10'd3, 16'h0004, 1);
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h000A) begin bad++; $display("FAIL udf_clear_status got=%h exp=000a", d); end
   endtask

   task automatic test_rx_full_simul();
      logic [15:0] d;
      rx_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rx_data = 16'h0100 + 16'(i);
         tick();
      end
      rx_valid = 1'b0;
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_full_ready got=%b exp=0", rx_ready); end
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h0006) begin bad++; $display("FAIL rx_full_status got=%h exp=0006", d); end
      // Pop at the end of the read coincides with a fabric push of 0xDEAD.
      cs = 1'b0; we = 1'b1; oe = 1'b0; address = 10'd2;
      tick();
      d = bus_rdata;
      bus_idle();
      rx_valid = 1'b1; rx_data = 16'hDEAD;
      tick();
      rx_valid = 1'b0;
      total++; if (d !== 16'h0100) begin bad++; $display("FAIL simul_head got=%h exp=0100", d); end
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL simul_ready got=%b exp=0", rx_ready); end
      for (int i = 1; i < 16; i++) begin
         bus_read(10'd2, 1, d);
         total++; if (d !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL rx_drain%0d got=%h exp=%h", i, d, 16'h0100 + 16'(i)); end
      end
      bus_read(10'd2, 1, d);
      total++; if (d !== 16'hDEAD) begin bad++; $display("FAIL rx_drain_last got=%h exp=dead", d); end
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h000A) begin bad++; $display("FAIL rx_drained_status got=%h exp=000a", d); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      cs = 1'b0; we = 1'b0; oe = 1'b1; address = 10'd1; bus_wdata = 16'h5555;
      tick();
      tick();
      we = 1'b1; oe = 1'b0; address = 10'd0;
      tick();
      tick();
      d = bus_rdata;
      bus_idle();
      tick();
      total++; if (d !== 16'h0008) begin bad++; $display("FAIL wr_to_rd_status got=%h exp=0008", d); end
      total++; if (tx_data !== 16'h5555 || tx_valid !== 1'b1) begin bad++; $display("FAIL wr_to_rd_push got=%h/%b exp=5555/1", tx_data, tx_valid); end
      bus_read(10'd1, 1, d);
      total++; if (d !== 16'h0000) begin bad++; $display("FAIL wo_read got=%h exp=0000", d); end
      bus_read(10'd5, 1, d);
      total++; if (d !== 16'h0000) begin bad++; $display("FAIL unmapped_read got=%h exp=0000", d); end
      bus_write(10'd0, 16'hFFFF, 1);
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h0008) begin bad++; $display("FAIL ro_write_ignored got=%h exp=0008", d); end
      bus_write(10'd3, 16'h0001, 1);
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h000A) begin bad++; $display("FAIL tx_flush_status got=%h exp=000a", d); end
   endtask

   task automatic test_level();
      logic [15:0] d;
      logic [15:0] exp_level;
`ifdef GPMC_FIFO_LEVEL_EN
      exp_level = 16'h0203;
`else
      exp_level = 16'h0000;
`endif
      for (int i = 0; i < 3; i++) bus_write(10'd1, 16'h0010 + 16'(i), 1);
      rx_push(16'h0020);
      rx_push(16'h0021);
      bus_read(10'd4, 1, d);
      total++; if (d !== exp_level) begin bad++; $display("FAIL level_read got=%h exp=%h", d, exp_level); end
      bus_write(10'd3, 16'h0003, 1);
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h000A) begin bad++; $display("FAIL flush_both_status got=%h exp=000a", d); end
   endtask

   task automatic test_reset_mid_write();
      logic [15:0] d;
      cs = 1'b0; we = 1'b0; oe = 1'b1; address = 10'd1; bus_wdata = 16'h7777;
      tick();
      tick();
      reset = 1'b1;
      #2;
      bus_idle();
      tick();
      reset = 1'b0;
      tick();
      tick();
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_tx_valid got=%b exp=0", tx_valid); end
      total++; if (bus_rdata !== 16'h0000) begin bad++; $display("FAIL mid_reset_rdata got=%h exp=0000", bus_rdata); end
      bus_read(10'd0, 1, d);
      total++; if (d !== 16'h000A) begin bad++; $display("FAIL mid_reset_status got=%h exp=000a", d); end
   endtask

   initial begin
      test_reset();
      test_tx_stream();
      test_tx_overflow();
      test_rx_underflow();
      test_rx_full_simul();
      test_back_to_back();
      test_level();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
